// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//
// Receives PS/2 keyboard frames, validates start/parity/stop, and tracks the
// currently held key plus a count of accepted new presses. All outputs are
// registered and only change on a completed frame or a frame abort, so a
// downstream seven-segment display never shows partial values.
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles without a PS/2 clock falling edge, mid-frame,
//                   before the partial frame is aborted.
//
// Ports:
//   clk        in   system clock (single domain)
//   rst        in   synchronous active-high reset
//   ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   raw PS/2 data pin (asynchronous)
//   key_code   out  scan code of the held key, 0x00 when none held
//   key_valid  out  high while a key is held
//   press_cnt  out  count of accepted new presses, wraps 255 -> 0
//   frame_err  out  one-cycle pulse on a rejected or aborted frame

module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic [7:0] press_cnt,
    output logic       frame_err
);

    localparam int             TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_BREAK
    } state_t;

    // Synchronizer and edge-detect flops
    logic            ps2c_s1_q, ps2c_s1_d;
    logic            ps2c_s2_q, ps2c_s2_d;
    logic            ps2c_prev_q, ps2c_prev_d;
    logic            ps2d_s1_q, ps2d_s1_d;
    logic            ps2d_s2_q, ps2d_s2_d;

    // Frame capture
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Byte FSM and outputs
    state_t          state_q, state_d;
    logic [7:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic [7:0]      press_cnt_q, press_cnt_d;
    logic            frame_err_q, frame_err_d;

    logic            fall;
    logic            timeout_hit;
    logic            frame_ok;
    logic [7:0]      rx_byte;

    assign fall        = ps2c_prev_q & ~ps2c_s2_q;
    assign timeout_hit = (bit_cnt_q != 4'd0) && (to_cnt_q == TO_MAX);

    // After ten falls the shift register holds start in [0], data in [8:1]
    // and parity in [9]; the stop bit is the live synced data on the 11th fall.
    assign rx_byte  = shift_q[8:1];
    assign frame_ok = ~shift_q[0] & ps2d_s2_q & (^shift_q[9:1]);

    always_comb begin
        ps2c_s1_d   = ps2_clk;
        ps2c_s2_d   = ps2c_s1_q;
        ps2c_prev_d = ps2c_s2_q;
        ps2d_s1_d   = ps2_data;
        ps2d_s2_d   = ps2d_s1_q;

        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        press_cnt_d = press_cnt_q;
        frame_err_d = 1'b0;

        if (fall || bit_cnt_q == 4'd0) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (timeout_hit) begin
            // Abort the partial frame; a coincident fall starts a new frame.
            frame_err_d = 1'b1;
            to_cnt_d    = '0;
            if (fall) begin
                bit_cnt_d = 4'd1;
                shift_d   = {ps2d_s2_q, shift_q[9:1]};
            end else begin
                bit_cnt_d = 4'd0;
            end
        end else if (fall) begin
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!frame_ok) begin
                    frame_err_d = 1'b1;
                end else if (rx_byte == 8'hE0) begin
                    // Extended-key prefix carries no information here.
                end else if (rx_byte == 8'hF0) begin
                    state_d = S_BREAK;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            key_code_d  = rx_byte;
                            key_valid_d = 1'b1;
                            press_cnt_d = press_cnt_q + 8'd1;
                            state_d     = S_HELD;
                        end
                        S_HELD: begin
                            if (rx_byte != key_code_q) begin
                                key_code_d  = rx_byte;
                                press_cnt_d = press_cnt_q + 8'd1;
                            end
                        end
                        default: begin
                            // key_valid_q is untouched while in S_BREAK, so it
                            // records whether a key was held before the F0.
                            if (key_valid_q && rx_byte == key_code_q) begin
                                key_code_d  = 8'h00;
                                key_valid_d = 1'b0;
                                state_d     = S_IDLE;
                            end else if (key_valid_q) begin
                                state_d = S_HELD;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    endcase
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {ps2d_s2_q, shift_q[9:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            state_q     <= S_IDLE;
            key_code_q  <= 8'h00;
            key_valid_q <= 1'b0;
            press_cnt_q <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            ps2c_s1_q   <= ps2c_s1_d;
            ps2c_s2_q   <= ps2c_s2_d;
            ps2c_prev_q <= ps2c_prev_d;
            ps2d_s1_q   <= ps2d_s1_d;
            ps2d_s2_q   <= ps2d_s2_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            press_cnt_q <= press_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign press_cnt = press_cnt_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker
//
// Self-checking bench for ps2_key_tracker: a directed vector table, hand
// sequences for timeout, mid-frame reset and counter wrap, then randomized
// frames compared against a byte-level behavioural model.

module tb_ps2_key_tracker;

    localparam int TIMEOUT = 100;
    localparam int HALF    = 5;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_valid;
    logic [7:0] press_cnt;
    logic       frame_err;

    int total;
    int bad;
    int errTotal;
    int errBase;

    // Behavioural model: what a keyboard user would observe
    logic [7:0] m_key;
    logic [7:0] m_cnt;
    bit         m_held;
    bit         m_brk;

    typedef struct {
        logic [7:0] code;
        int         kind;
        logic [7:0] exp_key;
        logic       exp_valid;
        logic [7:0] exp_cnt;
        int         exp_err;
    } vec_t;

    vec_t vecs[12];

    ps2_key_tracker #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .key_valid (key_valid),
        .press_cnt (press_cnt),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle frame_err is high, so a widened pulse shows up too.
    initial errTotal = 0;
    always @(negedge clk) begin
        if (frame_err === 1'b1) errTotal = errTotal + 1;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
    function automatic logic [10:0] makeFrame(input logic [7:0] code, input int kind);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = code;
        f[9]    = ~(^code);
        f[10]   = 1'b1;
        if (kind == 1) f[9]  = ~f[9];
        if (kind == 2) f[10] = 1'b0;
        if (kind == 3) f[0]  = 1'b1;
        return f;
    endfunction

    task automatic modelReset();
        m_key  = 8'h00;
        m_cnt  = 8'h00;
        m_held = 0;
        m_brk  = 0;
    endtask

    task automatic modelByte(input logic [7:0] c);
        if (c == 8'hE0) begin
        end else if (c == 8'hF0) begin
            m_brk = 1;
        end else if (m_brk) begin
            m_brk = 0;
            if (m_held && c == m_key) begin
                m_held = 0;
                m_key  = 8'h00;
            end
        end else if (!m_held || c != m_key) begin
            m_held = 1;
            m_key  = c;
            m_cnt  = m_cnt + 8'd1;
        end
    endtask

    task automatic sendBits(input logic [10:0] f, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            @(posedge clk); #1 ps2_data = f[b];
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        repeat (HALF) @(posedge clk);
        #1 ps2_data = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] code, input int kind);
        sendBits(makeFrame(code, kind), 11);
        if (kind == 0) modelByte(code);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic checkOutput(input string nm, input logic [7:0] ek, input logic ev,
                               input logic [7:0] ec, input int eerr);
        repeat (3) @(negedge clk);
        check({nm, ".key_code"},  key_code,  ek);
        check({nm, ".key_valid"}, {7'd0, key_valid}, {7'd0, ev});
        check({nm, ".press_cnt"}, press_cnt, ec);
        check({nm, ".err_cycles"}, 8'(errTotal - errBase), 8'(eerr));
    endtask

    task automatic pulseReset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        modelReset();
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;

        errBase = errTotal;
        checkOutput("reset", 8'h00, 1'b0, 8'h00, 0);

        // code, kind, expected key, valid, count, error cycles
        vecs[0]  = '{8'h1C, 0, 8'h1C, 1'b1, 8'd1, 0};
        vecs[1]  = '{8'h1C, 0, 8'h1C, 1'b1, 8'd1, 0};
        vecs[2]  = '{8'h1C, 0, 8'h1C, 1'b1, 8'd1, 0};
        vecs[3]  = '{8'h1C, 0, 8'h1C, 1'b1, 8'd1, 0};
        vecs[4]  = '{8'hF0, 0, 8'h1C, 1'b1, 8'd1, 0};
        vecs[5]  = '{8'h1C, 0, 8'h00, 1'b0, 8'd1, 0};
        vecs[6]  = '{8'hE0, 0, 8'h00, 1'b0, 8'd1, 0};
        vecs[7]  = '{8'h75, 0, 8'h75, 1'b1, 8'd2, 0};
        vecs[8]  = '{8'h1C, 1, 8'h75, 1'b1, 8'd2, 1};
        vecs[9]  = '{8'h1C, 2, 8'h75, 1'b1, 8'd2, 1};
        vecs[10] = '{8'h1C, 3, 8'h75, 1'b1, 8'd2, 1};
        vecs[11] = '{8'h75, 0, 8'h75, 1'b1, 8'd2, 0};

        for (int i = 0; i < 12; i++) begin
            errBase = errTotal;
            applyStimulus(vecs[i].code, vecs[i].kind);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_key, vecs[i].exp_valid,
                        vecs[i].exp_cnt, vecs[i].exp_err);
        end

        // Partial frame left hanging must abort once, then a clean frame works
        errBase = errTotal;
        sendBits(makeFrame(8'h1C, 0), 5);
        repeat (TIMEOUT + 20) @(posedge clk);
        checkOutput("timeout", 8'h75, 1'b1, 8'd2, 1);
        errBase = errTotal;
        applyStimulus(8'h29, 0);
        checkOutput("after_timeout", 8'h29, 1'b1, 8'd3, 0);

        // Reset in the middle of a frame, then the next frame starts clean
        errBase = errTotal;
        sendBits(makeFrame(8'h32, 0), 6);
        pulseReset();
        checkOutput("mid_reset", 8'h00, 1'b0, 8'h00, 0);
        errBase = errTotal;
        applyStimulus(8'h1C, 0);
        checkOutput("after_reset", 8'h1C, 1'b1, 8'd1, 0);

        // 256 alternating presses wrap the counter back to zero
        pulseReset();
        errBase = errTotal;
        for (int i = 0; i < 256; i++) begin
            applyStimulus((i % 2 == 0) ? 8'h1C : 8'h32, 0);
        end
        checkOutput("wrap", 8'h32, 1'b1, 8'h00, 0);

        // Randomized frames against the model
        for (int i = 0; i < 60; i++) begin
            logic [7:0] code;
            int         kind;
            int         sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0: code = 8'h1C;
                1: code = 8'h32;
                2, 3: code = 8'hF0;
                4: code = 8'hE0;
                5: code = m_key;
                default: code = 8'($urandom_range(0, 255));
            endcase
            kind = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 3)) : 0;
            errBase = errTotal;
            applyStimulus(code, kind);
            checkOutput($sformatf("rand%0d", i), m_key, m_held, m_cnt, (kind != 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
